// File: rtl/signed_accumulator_4b_pkg.sv
// rtl/signed_accumulator_4b_pkg.sv - shared opcodes and FSM state encoding for the signed accumulator
package signed_accumulator_4b_pkg;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/signed_accumulator_4b_addsub4.sv
// rtl/signed_accumulator_4b_addsub4.sv - combinational WIDTH-bit two's-complement adder/subtractor
module addsub4 #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             option,
  output logic [WIDTH-1:0] sum,
  output logic             ovf
);

  logic [WIDTH-1:0] b_eff;

  // Subtract as A + ~B + 1; the same sign rule then covers both ADD and SUB.
  always_comb begin
    b_eff = B ^ {WIDTH{option}};
    sum   = A + b_eff + {{(WIDTH-1){1'b0}}, option};
    ovf   = (A[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
  end

endmodule

// File: rtl/signed_accumulator_4b.sv
// rtl/signed_accumulator_4b.sv - registered signed accumulator with overflow flags and valid/ready handshakes
module signed_accumulator_4b
  import signed_accumulator_4b_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] acc,
  output logic             ovf,
  output logic             ovf_sticky,
  output logic [7:0]       op_count
);

  localparam logic [WIDTH-1:0] ACC_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] ACC_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state, state_d;
  logic [WIDTH-1:0] acc_d;
  logic             ovf_d, sticky_d;
  logic [7:0]       cnt_d;
  logic [WIDTH-1:0] as_sum;
  logic             as_ovf;

  addsub4 #(.WIDTH(WIDTH)) u_addsub (
    .A      (acc),
    .B      (in_data),
    .option (in_op[0]),
    .sum    (as_sum),
    .ovf    (as_ovf)
  );

  always_comb begin
    state_d  = state;
    acc_d    = acc;
    ovf_d    = ovf;
    sticky_d = ovf_sticky;
    cnt_d    = op_count;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_HOLD;
          cnt_d   = op_count + 8'd1;
          case (in_op)
            OP_ADD, OP_SUB: begin
              ovf_d    = as_ovf;
              sticky_d = ovf_sticky | as_ovf;
              if (SATURATE && as_ovf) acc_d = acc[WIDTH-1] ? ACC_MIN : ACC_MAX;
              else                    acc_d = as_sum;
            end
            OP_LOAD: begin
              acc_d = in_data;
              ovf_d = 1'b0;
            end
            default: begin
              acc_d    = '0;
              ovf_d    = 1'b0;
              sticky_d = 1'b0;
              cnt_d    = 8'd0;
            end
          endcase
        end
      end
      default: begin
        if (out_ready) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      acc        <= '0;
      ovf        <= 1'b0;
      ovf_sticky <= 1'b0;
      op_count   <= 8'd0;
    end else begin
      state      <= state_d;
      acc        <= acc_d;
      ovf        <= ovf_d;
      ovf_sticky <= sticky_d;
      op_count   <= cnt_d;
    end
  end

  // Handshake outputs come from the state register alone.
  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_HOLD);

endmodule

// File: tb/tb_signed_accumulator_4b.sv
// tb/tb_signed_accumulator_4b.sv - randomized and directed bench for wrap and saturate accumulators
module tb_signed_accumulator_4b;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = 4'd0;
  logic [1:0] in_op = 2'd0;
  logic       out_ready = 1'b0;

  logic       in_ready0, out_valid0, ovf0, sticky0;
  logic       in_ready1, out_valid1, ovf1, sticky1;
  logic [3:0] acc0, acc1;
  logic [7:0] cnt0, cnt1;

  int n_vec = 0;
  int n_err = 0;
  bit checking = 1'b0;

  always #5 clk = ~clk;

  signed_accumulator_4b #(.WIDTH(4), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .in_op(in_op), .out_valid(out_valid0), .out_ready(out_ready),
    .acc(acc0), .ovf(ovf0), .ovf_sticky(sticky0), .op_count(cnt0)
  );

  signed_accumulator_4b #(.WIDTH(4), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .in_op(in_op), .out_valid(out_valid1), .out_ready(out_ready),
    .acc(acc1), .ovf(ovf1), .ovf_sticky(sticky1), .op_count(cnt1)
  );

  task automatic check(input string name, input int actual, input int expected);
    n_vec++;
    if (actual !== expected) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Behavioural reference: integer arithmetic with explicit range test.
  bit m_busy;
  int m_acc[2], m_ovf[2], m_sticky[2], m_cnt[2];

  task automatic apply(input int sat, inout int a, inout int o, inout int s, inout int c,
                       input int op, input int d);
    int r;
    c = (c + 1) % 256;
    if (op == 0 || op == 1) begin
      r = (op == 0) ? a + d : a - d;
      o = (r > 7 || r < -8) ? 1 : 0;
      if (o == 1 && sat == 1) r = (r > 7) ? 7 : -8;
      else if (r > 7)  r = r - 16;
      else if (r < -8) r = r + 16;
      a = r;
      s = s | o;
    end else if (op == 2) begin
      a = d;
      o = 0;
    end else begin
      a = 0; o = 0; s = 0; c = 0;
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_busy = 1'b0;
      for (int k = 0; k < 2; k++) begin
        m_acc[k] = 0; m_ovf[k] = 0; m_sticky[k] = 0; m_cnt[k] = 0;
      end
    end else if (!m_busy) begin
      if (in_valid) begin
        for (int k = 0; k < 2; k++)
          apply(k, m_acc[k], m_ovf[k], m_sticky[k], m_cnt[k], int'(in_op), int'($signed(in_data)));
        m_busy = 1'b1;
      end
    end else if (out_ready) begin
      m_busy = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      check("in_ready_w",  int'(in_ready0),  int'(!m_busy));
      check("out_valid_w", int'(out_valid0), int'(m_busy));
      check("acc_w",       int'($signed(acc0)), m_acc[0]);
      check("ovf_w",       int'(ovf0),    m_ovf[0]);
      check("sticky_w",    int'(sticky0), m_sticky[0]);
      check("count_w",     int'(cnt0),    m_cnt[0]);
      check("in_ready_s",  int'(in_ready1),  int'(!m_busy));
      check("out_valid_s", int'(out_valid1), int'(m_busy));
      check("acc_s",       int'($signed(acc1)), m_acc[1]);
      check("ovf_s",       int'(ovf1),    m_ovf[1]);
      check("sticky_s",    int'(sticky1), m_sticky[1]);
      check("count_s",     int'(cnt1),    m_cnt[1]);
    end
  end

  // Presents one command from IDLE; returns at the negedge where the result is held.
  task automatic cmd(input logic [1:0] op, input logic [3:0] d);
    @(negedge clk);
    check("cmd_ready", int'(in_ready0), 1);
    in_valid = 1'b1; in_op = op; in_data = d; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before %0t", $time);
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checking = 1'b1;
    check("reset_acc", int'(acc0), 0);
    check("reset_in_ready", int'(in_ready0), 1);
    check("reset_out_valid", int'(out_valid0), 0);

    cmd(2'b10, 4'd3); drain();
    cmd(2'b00, 4'd2);
    check("lit_add5", int'(acc0), 5);
    check("lit_cnt2", int'(cnt0), 2);
    check("lit_ovf0", int'(ovf0), 0);
    drain();
    cmd(2'b01, 4'd3); drain();
    cmd(2'b01, 4'd3);
    check("lit_neg1", int'(acc0), 15);
    drain();

    cmd(2'b10, 4'd7); drain();
    cmd(2'b00, 4'd1);
    check("lit_wrap_acc", int'(acc0), 8);
    check("lit_wrap_ovf", int'(ovf0), 1);
    check("lit_wrap_sticky", int'(sticky0), 1);
    check("lit_sat_acc", int'(acc1), 7);
    check("lit_sat_ovf", int'(ovf1), 1);
    drain();
    cmd(2'b10, 4'd8); drain();
    cmd(2'b01, 4'd1);
    check("lit_wrap_sub", int'(acc0), 7);
    check("lit_sat_sub", int'(acc1), 8);
    drain();
    cmd(2'b10, 4'd0);
    check("lit_load_ovf", int'(ovf0), 0);
    check("lit_load_sticky", int'(sticky0), 1);
    drain();

    cmd(2'b00, 4'd1);
    in_valid = 1'b1; in_data = 4'd5; in_op = 2'b00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_acc", int'(acc0), 1);
      check("bp_valid", int'(out_valid0), 1);
      check("bp_ready", int'(in_ready0), 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_idle", int'(in_ready0), 1);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_accept", int'(acc0), 6);
    drain();

    cmd(2'b11, 4'd0); drain();
    for (int i = 0; i < 256; i++) begin
      cmd(2'b00, 4'd0); drain();
    end
    check("lit_cnt_wrap", int'(cnt0), 0);
    cmd(2'b10, 4'd7); drain();
    cmd(2'b00, 4'd7); drain();
    cmd(2'b11, 4'd5);
    check("lit_clr_acc", int'(acc0), 0);
    check("lit_clr_sticky", int'(sticky0), 0);
    check("lit_clr_cnt", int'(cnt0), 0);
    drain();

    cmd(2'b00, 4'd3);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("lit_rst_acc", int'(acc0), 0);
    check("lit_rst_valid", int'(out_valid0), 0);
    check("lit_rst_ready", int'(in_ready0), 1);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_op     = 2'($urandom_range(0, 3));
      if (in_op == 2'b11 && $urandom_range(0, 3) != 0) in_op = 2'($urandom_range(0, 1));
      in_data   = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 2) != 0);
      reset     = ($urandom_range(0, 63) == 0);
    end
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    checking = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
